// File: rtl/cram_pkg.sv
// cram_pkg: state encoding, strobe bundle and datapath control bit positions
// shared by cram_ctrl and cram_pwrup.
// Build option: CRAM_CTRL_CFG_EN adds the CellularRAM configuration states.
package cram_pkg;

   localparam int unsigned PWR_CNT_W     = 13;
   localparam int unsigned CFG_LAST_STEP = 7;

   // C_aTimer bit positions
   localparam int unsigned AT_CLR = 3;
   localparam int unsigned AT_RW  = 2;
   localparam int unsigned AT_PG  = 1;
   localparam int unsigned AT_DEC = 0;

   // C_Address bit positions
   localparam int unsigned ADR_LOAD = 1;
   localparam int unsigned ADR_INC  = 0;

   // C_HWords bit positions
   localparam int unsigned HW_LOAD = 1;
   localparam int unsigned HW_DEC  = 0;

   // C_Step bit positions
   localparam int unsigned STEP_CLR = 1;
   localparam int unsigned STEP_INC = 0;

   typedef enum logic [2:0] {
      ST_PWRUP     = 3'd0,
`ifdef CRAM_CTRL_CFG_EN
      ST_CFG_SETUP = 3'd1,
      ST_CFG_ACC   = 3'd2,
      ST_CFG_REC   = 3'd3,
`endif
      ST_IDLE      = 3'd4,
      ST_RD        = 3'd5,
      ST_RD_DONE   = 3'd6
   } state_t;

   // Active-low device strobes, kept together so they register as one bundle
   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic adv_n;
      logic lb_n;
      logic ub_n;
   } strb_t;

   localparam strb_t STRB_OFF = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                  adv_n: 1'b1, lb_n: 1'b1, ub_n: 1'b1};

   // Strobes for a 16-bit asynchronous device access (read or write)
   function automatic strb_t strb_access(input logic write);
      strb_t s;
      s       = STRB_OFF;
      s.ce_n  = 1'b0;
      s.adv_n = 1'b0;
      s.lb_n  = 1'b0;
      s.ub_n  = 1'b0;
      if (write) s.we_n = 1'b0;
      else       s.oe_n = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/cram_pwrup.sv
// cram_pwrup: power-up wait down-counter. o_done_c flags the last wait cycle,
// so the owning state lasts exactly PWR_CYCLES cycles.
module cram_pwrup
   import cram_pkg::*;
#(
   parameter int unsigned PWR_CYCLES = 7500
)
(
   input  logic aReset,
   input  logic Clock,
   input  logic i_en,
   output logic o_done_c
);

   logic [PWR_CNT_W-1:0] r_cnt;

   // Count down while enabled and hold at zero; reset reloads the full wait
   always_ff @(posedge Clock or posedge aReset) begin
      if (aReset) begin
         r_cnt <= PWR_CNT_W'(PWR_CYCLES);
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - PWR_CNT_W'(1);
      end
   end

   assign o_done_c = i_en && (r_cnt == PWR_CNT_W'(1));

endmodule

// File: rtl/cram_ctrl.sv
// cram_ctrl: CellularRAM controller FSM. Power-up wait, optional software
// configuration sequence, then page-mode burst reads on CPU request.
// Device strobes, Ready and Done are registered; datapath controls and
// DataValid are decoded from the current state and datapath status.
// Build option: CRAM_CTRL_CFG_EN enables the configuration sequence.
module cram_ctrl
   import cram_pkg::*;
#(
   parameter int unsigned PWR_CYCLES = 7500
)
(
   input  logic       aReset,
   input  logic       Clock,
   input  logic       Req,
   input  logic [2:0] ReqLength,
   output logic       Ready,
   output logic       DataValid,
   output logic       Done,
   output logic [1:0] C_Address,
   output logic [1:0] C_HWords,
   output logic [3:0] C_aTimer,
   output logic [1:0] C_Step,
   output logic       C_SA_A,
   output logic [1:0] C_SA_D,
   output logic       C_BusOut,
   input  logic       S_HWOne,
   input  logic       S_aTOne,
   input  logic [3:0] S_SOut,
   output logic       CRAM_CE_n,
   output logic       CRAM_OE_n,
   output logic       CRAM_WE_n,
   output logic       CRAM_ADV_n,
   output logic       CRAM_LB_n,
   output logic       CRAM_UB_n
);

   state_t     r_state;
   strb_t      r_strb;
   logic       r_ready;
   logic       r_done;
   logic       w_pwr_done;
   logic       w_rd_go;
   logic [1:0] w_adr;
   logic [1:0] w_hw;
   logic [3:0] w_at;
   logic [1:0] w_step;
   logic       w_dv;
`ifdef CRAM_CTRL_CFG_EN
   logic       w_sa_a;
   logic [1:0] w_sa_d;
   logic       w_bus;
   logic       w_last_step;

   assign w_last_step = (S_SOut == 4'(CFG_LAST_STEP));
`else
   logic       w_unused_sout;

   assign w_unused_sout = ^S_SOut;
`endif

   cram_pwrup #(
      .PWR_CYCLES (PWR_CYCLES)
   ) u_pwrup (
      .aReset   (aReset),
      .Clock    (Clock),
      .i_en     (r_state == ST_PWRUP),
      .o_done_c (w_pwr_done)
   );

   assign w_rd_go = Req && (ReqLength != 3'd0);

   // State register plus registered strobes, Ready and Done for the next cycle
   always_ff @(posedge Clock or posedge aReset) begin
      if (aReset) begin
         r_state <= ST_PWRUP;
         r_strb  <= STRB_OFF;
         r_ready <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_strb  <= STRB_OFF;
         r_ready <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            ST_PWRUP: begin
               if (w_pwr_done) begin
`ifdef CRAM_CTRL_CFG_EN
                  r_state <= ST_CFG_SETUP;
`else
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
`endif
               end
            end
`ifdef CRAM_CTRL_CFG_EN
            ST_CFG_SETUP: begin
               r_state <= ST_CFG_ACC;
               r_strb  <= strb_access(S_SOut[1]);
            end
            ST_CFG_ACC: begin
               if (S_aTOne) r_state <= ST_CFG_REC;
               else         r_strb  <= strb_access(S_SOut[1]);
            end
            ST_CFG_REC: begin
               if (w_last_step) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= ST_CFG_SETUP;
               end
            end
`endif
            ST_IDLE: begin
               if (w_rd_go) begin
                  r_state <= ST_RD;
                  r_strb  <= strb_access(1'b0);
               end else if (Req) begin
                  r_state <= ST_RD_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            ST_RD: begin
               // CE_n stays low across the whole burst (page mode)
               if (S_aTOne && S_HWOne) begin
                  r_state <= ST_RD_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_strb  <= strb_access(1'b0);
               end
            end
            ST_RD_DONE: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
            default: r_state <= ST_PWRUP;
         endcase
      end
   end

   // Datapath controls and DataValid; all held at zero while aReset is high
   always_comb begin
      w_adr  = '0;
      w_hw   = '0;
      w_at   = '0;
      w_step = '0;
      w_dv   = 1'b0;
`ifdef CRAM_CTRL_CFG_EN
      w_sa_a = 1'b0;
      w_sa_d = '0;
      w_bus  = 1'b0;
`endif
      if (!aReset) begin
         case (r_state)
            ST_PWRUP: begin
               w_at[AT_CLR]     = 1'b1;
               w_step[STEP_CLR] = 1'b1;
            end
`ifdef CRAM_CTRL_CFG_EN
            ST_CFG_SETUP: w_at[AT_RW] = 1'b1;
            ST_CFG_ACC: begin
               w_sa_a       = 1'b1;
               w_sa_d       = {S_SOut[2], S_SOut[0]};
               w_bus        = S_SOut[1];
               w_at[AT_DEC] = 1'b1;
            end
            ST_CFG_REC: begin
               w_step[STEP_INC] = 1'b1;
               if (w_last_step) w_step[STEP_CLR] = 1'b1;
            end
`endif
            ST_IDLE: begin
               if (w_rd_go) begin
                  w_adr[ADR_LOAD] = 1'b1;
                  w_hw[HW_LOAD]   = 1'b1;
                  w_at[AT_RW]     = 1'b1;
               end
            end
            ST_RD: begin
               w_at[AT_DEC] = 1'b1;
               if (S_aTOne) begin
                  w_dv = 1'b1;
                  if (!S_HWOne) begin
                     // Next half-word comes from the open page: shorter page timer
                     w_adr[ADR_INC] = 1'b1;
                     w_hw[HW_DEC]   = 1'b1;
                     w_at[AT_PG]    = 1'b1;
                     w_at[AT_DEC]   = 1'b0;
                  end
               end
            end
            ST_RD_DONE: w_at[AT_CLR] = 1'b1;
            default: ;
         endcase
      end
   end

   assign C_Address  = w_adr;
   assign C_HWords   = w_hw;
   assign C_aTimer   = w_at;
   assign C_Step     = w_step;
   assign DataValid  = w_dv;
`ifdef CRAM_CTRL_CFG_EN
   assign C_SA_A     = w_sa_a;
   assign C_SA_D     = w_sa_d;
   assign C_BusOut   = w_bus;
`else
   assign C_SA_A     = 1'b0;
   assign C_SA_D     = 2'b00;
   assign C_BusOut   = 1'b0;
`endif
   assign Ready      = r_ready;
   assign Done       = r_done;
   assign CRAM_CE_n  = r_strb.ce_n;
   assign CRAM_OE_n  = r_strb.oe_n;
   assign CRAM_WE_n  = r_strb.we_n;
   assign CRAM_ADV_n = r_strb.adv_n;
   assign CRAM_LB_n  = r_strb.lb_n;
   assign CRAM_UB_n  = r_strb.ub_n;

endmodule
